// File: rtl/load_store_unit.sv
// RV32I load/store stage: word-aligned valid/ready data-memory port,
// byte/half/word lane steering, load extension and error flagging.
// Optional macro LSU_TIMEOUT_EN adds a REQ+WAIT response timeout.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [1:0]        err_cause,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              store_q, store_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        cause_q, cause_d;

    logic        illegal;
    logic        misal;
    logic        tmo;
    logic [31:0] ld_val;
    logic [3:0]  strb;
    logic [31:0] wlane;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ?
                        8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles spent in REQ/WAIT; restart whenever REQ is entered
    always_comb begin
        cnt_d = '0;
        if (state_q == S_REQ || state_q == S_WAIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo = 1'b0;
`endif

    // Classify the incoming request; illegal width wins over alignment
    always_comb begin
        illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                  (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        misal = 1'b0;
        unique case (1'b1)
            (req_funct3[1:0] == 2'b01): misal = req_addr[0];
            (req_funct3[1:0] == 2'b10): misal = |req_addr[1:0];
            default:                    misal = 1'b0;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   ld_b = mem_rdata[7:0];
            2'b01:   ld_b = mem_rdata[15:8];
            2'b10:   ld_b = mem_rdata[23:16];
            default: ld_b = mem_rdata[31:24];
        endcase
        ld_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_val = {24'h0, ld_b};
            3'b101:  ld_val = {16'h0, ld_h};
            default: ld_val = mem_rdata;
        endcase
    end

    // Byte strobes and lane-replicated store data
    always_comb begin
        strb  = 4'b0000;
        wlane = wdata_q;
        if (store_q) begin
            unique case (f3_q[1:0])
                2'b00: begin
                    strb  = 4'b0001 << addr_q[1:0];
                    wlane = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    strb  = 4'b0011 << {addr_q[1], 1'b0};
                    wlane = {2{wdata_q[15:0]}};
                end
                default: begin
                    strb  = 4'b1111;
                    wlane = wdata_q;
                end
            endcase
        end
    end

    // Access sequencing: IDLE -> REQ -> WAIT -> DONE, errors skip to DONE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        store_d = store_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    store_d = req_store;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (illegal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        cause_d = 2'b10;
                    end else if (misal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        cause_d = 2'b01;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready && mem_rvalid) begin
                    state_d = S_DONE;
                    rdata_d = store_q ? 32'h0 : ld_val;
                end else if (mem_ready) begin
                    state_d = S_WAIT;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    cause_d = 2'b11;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_DONE;
                    rdata_d = store_q ? 32'h0 : ld_val;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    cause_d = 2'b11;
                end
            end
            default: begin
                state_d = S_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
                cause_d = 2'b00;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cause_q <= cause_d;
        end
    end

    assign done      = (state_q == S_DONE);
    assign stall     = req_valid & ~done;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign err_cause = cause_q;
    assign mem_valid = (state_q == S_REQ);
    assign mem_we    = mem_valid & store_q;
    assign mem_addr  = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wstrb = mem_valid ? strb : 4'b0000;
    assign mem_wdata = mem_valid ? wlane : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors,
// wait states, reset abort and (with LSU_TIMEOUT_EN) timeout.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_cause;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    load_store_unit #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .err_cause  (err_cause),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // Zero-wait access: accept N, ready N+1, rvalid N+2, done N+3
    task automatic access(input string tag, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word,
                          input logic [31:0] exp_rd,
                          input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd);
        set_req(st, f3, a, wd);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk({tag, ".stall"}, stall, 1);
        tick();
        chk({tag, ".valid"}, mem_valid, 1);
        chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ".we"}, mem_we, st);
        chk({tag, ".strb"}, mem_wstrb, exp_strb);
        if (st) chk({tag, ".wdata"}, mem_wdata, exp_wd);
        chk({tag, ".done1"}, done, 0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk({tag, ".valid2"}, mem_valid, 0);
        chk({tag, ".done2"}, done, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        chk({tag, ".done3"}, done, 1);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".rdata"}, rdata, exp_rd);
        chk({tag, ".stall3"}, stall, 0);
        req_valid = 1'b0;
        tick();
        chk({tag, ".done4"}, done, 0);
    endtask

    // Rejected access: done one cycle after accept, memory untouched
    task automatic bad(input string tag, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [1:0] cause);
        set_req(st, f3, a, 32'h5555_AAAA);
        #1;
        chk({tag, ".valid0"}, mem_valid, 0);
        tick();
        chk({tag, ".done"}, done, 1);
        chk({tag, ".err"}, err, 1);
        chk({tag, ".cause"}, err_cause, cause);
        chk({tag, ".rdata"}, rdata, 0);
        chk({tag, ".valid1"}, mem_valid, 0);
        req_valid = 1'b0;
        tick();
        chk({tag, ".done2"}, done, 0);
        chk({tag, ".valid2"}, mem_valid, 0);
    endtask

    initial begin
        int cyc;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.cause", err_cause, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.valid", mem_valid, 0);
        chk("rst.we", mem_we, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.strb", mem_wstrb, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.stall", stall, 0);
        rst_n = 1'b1;
        tick();

        access("lw100", 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 4'b0000, 0);
        access("lb103", 0, 3'b000, 32'h103, 0, 32'h80FF_0000,
               32'hFFFF_FF80, 4'b0000, 0);
        access("lbu103", 0, 3'b100, 32'h103, 0, 32'h80FF_0000,
               32'h0000_0080, 4'b0000, 0);
        access("lh102", 0, 3'b001, 32'h102, 0, 32'h80FF_0000,
               32'hFFFF_80FF, 4'b0000, 0);
        access("lhu100", 0, 3'b101, 32'h100, 0, 32'h1234_8001,
               32'h0000_8001, 4'b0000, 0);
        access("lb101", 0, 3'b000, 32'h101, 0, 32'h0000_7F00,
               32'h0000_007F, 4'b0000, 0);
        access("sh102", 1, 3'b001, 32'h102, 32'h1234_ABCD, 0,
               0, 4'b1100, 32'hABCD_ABCD);
        access("sb101", 1, 3'b000, 32'h101, 32'hCAFE_0077, 0,
               0, 4'b0010, 32'h7777_7777);
        access("sw104", 1, 3'b010, 32'h104, 32'h0BAD_F00D, 0,
               0, 4'b1111, 32'h0BAD_F00D);

        bad("lw101", 0, 3'b010, 32'h101, 2'b01);
        bad("lh103", 0, 3'b001, 32'h103, 2'b01);
        bad("f3_011", 0, 3'b011, 32'h101, 2'b10);
        bad("sbu", 1, 3'b100, 32'h100, 2'b10);
        bad("f3_111", 0, 3'b111, 32'h100, 2'b10);

        // Back-pressure: ready low 3 cycles, rvalid 2 cycles later
        set_req(0, 3'b010, 32'h20B, 0);
        req_funct3 = 3'b000;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ws.valid", mem_valid, 1);
            chk("ws.addr", mem_addr, 32'h208);
            chk("ws.done", done, 0);
            mem_rvalid = (i == 1);
            mem_rdata  = 32'h1111_1111;
            tick();
        end
        mem_rvalid = 1'b0;
        chk("ws.addr3", mem_addr, 32'h208);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("ws.wvalid", mem_valid, 0);
            chk("ws.wdone", done, 0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9A00_0000;
        tick();
        mem_rvalid = 1'b0;
        chk("ws.done1", done, 1);
        chk("ws.rdata", rdata, 32'hFFFF_FF9A);
        req_valid = 1'b0;
        tick();
        chk("ws.done0", done, 0);

        // Ready and rvalid in the same cycle finish straight away
        set_req(0, 3'b101, 32'h302, 0);
        tick();
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hF00F_1234;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("same.done", done, 1);
        chk("same.rdata", rdata, 32'h0000_F00F);
        req_valid = 1'b0;
        tick();

        // Reset while in WAIT aborts; a late rvalid is ignored
        set_req(0, 3'b010, 32'h400, 0);
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rw.valid", mem_valid, 0);
        chk("rw.done", done, 0);
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("rw.late", done, 0);
        chk("rw.rdata", rdata, 0);
        tick();
        chk("rw.late2", done, 0);
        access("post_rst", 0, 3'b100, 32'h402, 0, 32'h00A5_0000,
               32'h0000_00A5, 4'b0000, 0);

`ifdef LSU_TIMEOUT_EN
        // Silent memory: timeout after 4 REQ cycles, cause 11
        set_req(0, 3'b010, 32'h500, 0);
        tick();
        cyc = 0;
        while (!done && cyc < 20) begin
            chk("to.valid", mem_valid, 1);
            cyc++;
            tick();
        end
        chk("to.cycles", cyc, 4);
        chk("to.done", done, 1);
        chk("to.err", err, 1);
        chk("to.cause", err_cause, 2'b11);
        chk("to.vdrop", mem_valid, 0);
        req_valid = 1'b0;
        tick();
`else
        // Without the timeout a silent memory keeps the request open
        set_req(0, 3'b010, 32'h500, 0);
        tick();
        cyc = 0;
        while (!done && cyc < 20) begin
            cyc++;
            tick();
        end
        chk("nto.done", done, 0);
        chk("nto.valid", mem_valid, 1);
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_0001;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("nto.done1", done, 1);
        chk("nto.err", err, 0);
        chk("nto.rdata", rdata, 32'h7777_0001);
        req_valid = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
